// File: rtl/led_event_blinker.sv
// led_event_blinker
// Converts single-cycle event pulses into human-visible LED blinks. Each blink
// is ON_CYCLES cycles lit followed by OFF_CYCLES cycles dark, then at least one
// idle cycle. Events that arrive while a blink is running are queued in a
// saturating pending counter. Once the counter is full, further events are
// dropped and a sticky overflow flag is set.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET_N        asynchronous active-low reset
//   EVENT          one-cycle event request; each high cycle is one event
//   ENABLE         1 = a blink may start from idle; 0 = keep queued events
//   CLEAR_OVERFLOW one-cycle clear of OVERFLOW (a set in the same cycle wins)
//   LED_N          registered LED drive, 0 = lit
//   BUSY           registered, 1 while a blink (on or off phase) is in progress
//   PENDING        queued events that have not yet started a blink
//   OVERFLOW       sticky flag, an event was dropped
module led_event_blinker #(
    parameter int unsigned ON_CYCLES  = 4000000,
    parameter int unsigned OFF_CYCLES = 4000000,
    parameter int unsigned PEND_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  EVENT,
    input  logic                  ENABLE,
    input  logic                  CLEAR_OVERFLOW,
    output logic                  LED_N,
    output logic                  BUSY,
    output logic [PEND_WIDTH-1:0] PENDING,
    output logic                  OVERFLOW
);

    localparam int unsigned TIMER_W = 32;
    localparam logic [TIMER_W-1:0]    ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [PEND_WIDTH-1:0]   pend_q,  pend_d;
    logic                    ovf_q,   ovf_d;
    logic                    led_n_q, led_n_d;
    logic                    busy_q,  busy_d;
    logic                    start_c;

    // State, timer, queue and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_n_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_n_q <= led_n_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, timer, pending-queue and output logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        led_n_d = 1'b1;
        busy_d  = 1'b0;

        // A blink starts from idle on a queued event or one arriving right now
        start_c = (state_q == ST_IDLE) && ENABLE && ((pend_q != '0) || EVENT);

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end
            end
            ST_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_OFF;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_OFF: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Queue: next = pending + event - start, saturating; a drop beats a clear
        if (CLEAR_OVERFLOW) begin
            ovf_d = 1'b0;
        end
        if (EVENT && !start_c) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_WIDTH'(1);
            end
        end else if (!EVENT && start_c) begin
            pend_d = pend_q - PEND_WIDTH'(1);
        end

        // Outputs registered from the next state so they change with it
        led_n_d = (state_d != ST_ON);
        busy_d  = (state_d != ST_IDLE);
    end

    assign LED_N    = led_n_q;
    assign BUSY     = busy_q;
    assign PENDING  = pend_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_led_event_blinker.sv
// Bench for led_event_blinker with ON=3, OFF=2, PEND_WIDTH=2.
// The reference model tracks the number of busy cycles left in the current
// blink plus a plain integer queue count. Every negedge outside reset, the
// DUT outputs are compared with the model. Directed sequences pin the model
// to hand-computed values, and a random phase follows them.
module tb_led_event_blinker;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PW  = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          CLK;
    logic          RESET_N;
    logic          EVENT;
    logic          ENABLE;
    logic          CLEAR_OVERFLOW;
    logic          LED_N;
    logic          BUSY;
    logic [PW-1:0] PENDING;
    logic          OVERFLOW;

    int checks = 0;
    int errors = 0;

    // model state
    int m_left = 0;   // busy cycles remaining after the latest edge
    int m_pend = 0;
    bit m_ovf  = 0;
    bit m_start;

    int blinks = 0;
    logic prev_led = 1'b1;

    led_event_blinker #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_WIDTH(PW)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .EVENT         (EVENT),
        .ENABLE        (ENABLE),
        .CLEAR_OVERFLOW(CLEAR_OVERFLOW),
        .LED_N         (LED_N),
        .BUSY          (BUSY),
        .PENDING       (PENDING),
        .OVERFLOW      (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a blink occupies ON+OFF busy cycles, lit for the first ON
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_left = 0;
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            m_start = (m_left == 0) && ENABLE && (m_pend != 0 || EVENT);
            if (CLEAR_OVERFLOW) m_ovf = 0;
            if (EVENT && !m_start) begin
                if (m_pend == PMAX) m_ovf = 1;
                else m_pend = m_pend + 1;
            end else if (!EVENT && m_start) begin
                m_pend = m_pend - 1;
            end
            if (m_start) m_left = ON + OFF;
            else if (m_left > 0) m_left = m_left - 1;
        end
    end

    // Per-cycle comparison against the model, plus blink counting
    always @(negedge CLK) begin
        if (RESET_N) begin
            check("led_n",    int'(LED_N),    (m_left > OFF) ? 0 : 1);
            check("busy",     int'(BUSY),     (m_left > 0) ? 1 : 0);
            check("pending",  int'(PENDING),  m_pend);
            check("overflow", int'(OVERFLOW), int'(m_ovf));
        end
        if (prev_led && !LED_N) blinks++;
        prev_led = LED_N;
    end

    // Apply inputs at a negedge, return at the following negedge
    task automatic step(input logic ev, input logic en, input logic clr);
        EVENT = ev;
        ENABLE = en;
        CLEAR_OVERFLOW = clr;
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0);
    endtask

    initial begin
        logic [5:0] exp_led;
        logic [5:0] exp_busy;
        int b0;

        RESET_N = 1'b0;
        EVENT = 1'b0;
        ENABLE = 1'b0;
        CLEAR_OVERFLOW = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_led_n",    int'(LED_N),    1);
        check("rst_busy",     int'(BUSY),     0);
        check("rst_pending",  int'(PENDING),  0);
        check("rst_overflow", int'(OVERFLOW), 0);
        RESET_N = 1'b1;
        idle(2, 1'b1);

        // Single event: lit for 3 cycles, busy for 5, queue untouched
        exp_led  = 6'b111000;
        exp_busy = 6'b011111;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b0, 1'b1, 1'b0);
            check("single_led",  int'(LED_N), int'(exp_led[i]));
            check("single_busy", int'(BUSY),  int'(exp_busy[i]));
            check("single_pend", int'(PENDING), 0);
        end
        idle(2, 1'b1);

        // Burst of 5: first starts, queue fills to 3, fifth is dropped
        b0 = blinks;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("burst_pend", int'(PENDING),  3);
        check("burst_ovf",  int'(OVERFLOW), 1);
        idle(30, 1'b1);
        check("burst_blinks", blinks - b0, 4);
        check("burst_drain",  int'(PENDING), 0);
        step(1'b0, 1'b1, 1'b1);
        check("clear_alone", int'(OVERFLOW), 0);

        // Held queue while disabled, then back-to-back drain
        b0 = blinks;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("hold_pend", int'(PENDING), 3);
        check("hold_led",  int'(LED_N),   1);
        check("hold_busy", int'(BUSY),    0);
        step(1'b0, 1'b1, 1'b0);
        check("drain_start_pend", int'(PENDING), 2);
        idle(6, 1'b1);
        check("drain_second_pend", int'(PENDING), 1);
        check("drain_second_led",  int'(LED_N),   0);
        idle(20, 1'b1);
        check("hold_blinks", blinks - b0, 3);

        // Event coincident with a start keeps the queue level
        b0 = blinks;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("coinc_pend", int'(PENDING), 2);
        idle(24, 1'b1);
        check("coinc_blinks", blinks - b0, 3);

        // Reset mid-ON darkens at once and discards the queue
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("pre_rst_led",  int'(LED_N),   0);
        check("pre_rst_pend", int'(PENDING), 2);
        #2 RESET_N = 1'b0;
        #1;
        check("async_led",  int'(LED_N),   1);
        check("async_pend", int'(PENDING), 0);
        check("async_busy", int'(BUSY),    0);
        @(negedge CLK);
        RESET_N = 1'b1;
        b0 = blinks;
        idle(10, 1'b1);
        check("post_rst_blinks", blinks - b0, 0);

        // Overflow set wins over a same-cycle clear
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check("ovf_set", int'(OVERFLOW), 1);
        step(1'b1, 1'b0, 1'b1);
        check("ovf_priority", int'(OVERFLOW), 1);
        step(1'b0, 1'b0, 1'b1);
        check("ovf_clear", int'(OVERFLOW), 0);
        idle(25, 1'b1);

        // Random phase, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
